// File: rtl/main_clock.sv
// 24-hour BCD clock with alarm, hourly chime flag and a scanned 4-digit 7-segment display.
// Latency: tick/scan updates are visible one cycle later. Outputs other than Choose are combinational from registers and inputs.
module main_clock #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       CP50,
  input  logic       nCR,
  input  logic       Ctrl24To12,
  input  logic       EN,
  input  logic       SwitchMHToS,
  input  logic       DisplayA,
  input  logic       AdjH,
  input  logic       AdjM,
  output logic       LEDAlarm,
  output logic       LED0,
  output logic       LEDZ,
  output logic [3:0] Choose,
  output logic [6:0] HEX
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit;
  logic [7:0]    sec, min, hour;
  logic [7:0]    alarm_min, alarm_hour;

  logic tick, scan_step;
  logic adj_time_m, adj_time_h, adj_alarm_m, adj_alarm_h;
  logic sec_wrap, min_step, min_wrap, hour_step;

  // BCD increment with wrap to 00 after max
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = v + 8'h01;
    return r;
  endfunction

  function automatic logic [7:0] to_12h(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h00)
      r = 8'h12;
    else if (h == 8'h20)
      r = 8'h08;
    else if (h == 8'h21)
      r = 8'h09;
    else if (h >= 8'h13)
      r = h - 8'h12;
    else
      r = h;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick      = (div_cnt == CW'(CLK_DIV - 1));
  assign scan_step = (scan_cnt == SW'(SCAN_DIV - 1));

  assign adj_time_m  = AdjM & ~DisplayA;
  assign adj_time_h  = AdjH & ~DisplayA;
  assign adj_alarm_m = AdjM & DisplayA;
  assign adj_alarm_h = AdjH & DisplayA;

  // Adjusting a field swallows the carry that would otherwise ripple out of the field below it
  assign sec_wrap  = EN & (sec == 8'h59);
  assign min_step  = adj_time_m | sec_wrap;
  assign min_wrap  = ~adj_time_m & sec_wrap & (min == 8'h59);
  assign hour_step = adj_time_h | min_wrap;

  always_ff @(posedge CP50) begin
    if (nCR) begin
      div_cnt    <= '0;
      scan_cnt   <= '0;
      digit      <= 2'd0;
      sec        <= 8'h00;
      min        <= 8'h00;
      hour       <= 8'h00;
      alarm_min  <= 8'h00;
      alarm_hour <= 8'h06;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + CW'(1);
      scan_cnt <= scan_step ? '0 : scan_cnt + SW'(1);
      if (scan_step)
        digit <= digit + 2'd1;
      if (tick) begin
        if (EN)
          sec <= bcd_inc(sec, 8'h59);
        if (min_step)
          min <= bcd_inc(min, 8'h59);
        if (hour_step)
          hour <= bcd_inc(hour, 8'h23);
        if (adj_alarm_m)
          alarm_min <= bcd_inc(alarm_min, 8'h59);
        if (adj_alarm_h)
          alarm_hour <= bcd_inc(alarm_hour, 8'h23);
      end
    end
  end

  assign LEDAlarm = ({hour, min} == {alarm_hour, alarm_min});
  assign LEDZ     = (min == 8'h59) & (sec[7:4] == 4'd5) & sec[0];
  assign LED0     = Ctrl24To12 & (hour >= 8'h12);
  assign Choose   = 4'b0001 << digit;

  logic [7:0] left_pair, right_pair, shown_hour;
  logic [3:0] digit_val;

  always_comb begin
    shown_hour = DisplayA ? alarm_hour : hour;
    if (Ctrl24To12)
      shown_hour = to_12h(shown_hour);
    if (DisplayA) begin
      left_pair  = shown_hour;
      right_pair = alarm_min;
    end else if (SwitchMHToS) begin
      left_pair  = min;
      right_pair = sec;
    end else begin
      left_pair  = shown_hour;
      right_pair = min;
    end
    case (digit)
      2'd0:    digit_val = right_pair[3:0];
      2'd1:    digit_val = right_pair[7:4];
      2'd2:    digit_val = left_pair[3:0];
      default: digit_val = left_pair[7:4];
    endcase
    HEX = seg7(digit_val);
  end

endmodule

// File: tb/tb_main_clock.sv
// Randomized scoreboard bench for main_clock with a plain-integer time model.
module tb_main_clock;
  localparam int CD = 4;
  localparam int SD = 2;

  logic       CP50 = 1'b0;
  logic       nCR = 1'b1, Ctrl24To12 = 1'b0, EN = 1'b0, SwitchMHToS = 1'b0;
  logic       DisplayA = 1'b0, AdjH = 1'b0, AdjM = 1'b0;
  logic       LEDAlarm, LED0, LEDZ;
  logic [3:0] Choose;
  logic [6:0] HEX;

  main_clock #(.CLK_DIV(CD), .SCAN_DIV(SD)) dut (
    .CP50(CP50), .nCR(nCR), .Ctrl24To12(Ctrl24To12), .EN(EN),
    .SwitchMHToS(SwitchMHToS), .DisplayA(DisplayA), .AdjH(AdjH), .AdjM(AdjM),
    .LEDAlarm(LEDAlarm), .LED0(LED0), .LEDZ(LEDZ), .Choose(Choose), .HEX(HEX)
  );

  always #5 CP50 = ~CP50;

  typedef struct packed {
    logic       la, l0, lz;
    logic [3:0] ch;
    logic [6:0] hx;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // reference model state
  int h, m, s, ah, am, n;
  bit live = 0;
  logic [6:0] seg_tab [10];

  // next input values applied just after each edge
  logic x_rst = 1'b1, x_ctrl = 1'b0, x_en = 1'b0, x_sw = 1'b0, x_da = 1'b0, x_ah = 1'b0, x_am = 1'b0;

  function automatic int disp_hour(input int hr, input logic c);
    if (!c) return hr;
    if (hr == 0) return 12;
    if (hr > 12) return hr - 12;
    return hr;
  endfunction

  task automatic model_tick();
    bit sw, mw;
    sw = 0; mw = 0;
    if (EN) begin
      sw = (s == 59);
      s = (s + 1) % 60;
    end
    if (!DisplayA && AdjM) m = (m + 1) % 60;
    else if (sw) begin
      mw = (m == 59);
      m = (m + 1) % 60;
    end
    if (!DisplayA && AdjH) h = (h + 1) % 24;
    else if (mw) h = (h + 1) % 24;
    if (DisplayA && AdjM) am = (am + 1) % 60;
    if (DisplayA && AdjH) ah = (ah + 1) % 24;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int lp, rp, idx, dv;
    idx = (n / SD) % 4;
    if (DisplayA) begin
      lp = disp_hour(ah, Ctrl24To12); rp = am;
    end else if (SwitchMHToS) begin
      lp = m; rp = s;
    end else begin
      lp = disp_hour(h, Ctrl24To12); rp = m;
    end
    case (idx)
      0: dv = rp % 10;
      1: dv = rp / 10;
      2: dv = lp % 10;
      default: dv = lp / 10;
    endcase
    e.la = (h == ah) && (m == am);
    e.l0 = Ctrl24To12 && (h >= 12);
    e.lz = (m == 59) && (s >= 51) && (s % 2 == 1);
    e.ch = 4'(1 << idx);
    e.hx = seg_tab[dv];
    return e;
  endfunction

  task automatic step();
    @(posedge CP50);
    if (nCR) begin
      h = 0; m = 0; s = 0; ah = 6; am = 0; n = 0; live = 1;
    end else if (live) begin
      if ((n + 1) % CD == 0) model_tick();
      n++;
    end
    #1;
    nCR = x_rst; Ctrl24To12 = x_ctrl; EN = x_en; SwitchMHToS = x_sw;
    DisplayA = x_da; AdjH = x_ah; AdjM = x_am;
    if (live) q.push_back(expect_now());
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h (model %0d:%0d:%0d alarm %0d:%0d)",
               name, $time, act, req, h, m, s, ah, am);
    end
  endtask

  always @(negedge CP50) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("led_alarm", int'(LEDAlarm), int'(e.la));
      chk("led0", int'(LED0), int'(e.l0));
      chk("ledz", int'(LEDZ), int'(e.lz));
      chk("choose", int'(Choose), int'(e.ch));
      chk("hex", int'(HEX), int'(e.hx));
    end
  end

  task automatic rand_view();
    x_ctrl = 1'($urandom_range(0, 1));
    x_sw   = 1'($urandom_range(0, 1));
  endtask

  // Steer time (da=0) or alarm (da=1) to th:tm using the adjust inputs, time frozen
  task automatic steer(input bit da, input int th, input int tm);
    int budget;
    budget = 3000;
    x_rst = 0; x_en = 0; x_da = da;
    while (budget > 0) begin
      if (da ? (ah == th && am == tm) : (h == th && m == tm)) break;
      x_ah = da ? (ah != th) : (h != th);
      x_am = da ? (am != tm) : (m != tm);
      rand_view();
      step();
      budget--;
    end
    if (budget == 0) begin
      failures++;
      $display("FAIL steer timeout: target %0d:%0d not reached", th, tm);
    end
    x_ah = 0; x_am = 0; x_da = 0;
    step();
  endtask

  task automatic run(input int cycles, input bit en, input bit randview);
    x_rst = 0; x_en = en; x_ah = 0; x_am = 0; x_da = 0;
    for (int i = 0; i < cycles; i++) begin
      if (randview) rand_view();
      step();
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    // reset held, then release and count past the first minute
    repeat (3) step();
    x_rst = 0; x_en = 1; x_sw = 1;
    run(250, 1, 0);
    run(60, 1, 1);

    // midnight rollover through the chime window
    steer(0, 23, 59);
    run(280, 1, 1);

    // frozen time, then minute adjust wrapping at 59
    run(40, 0, 1);
    steer(0, 5, 57);
    x_am = 1; x_en = 0;
    for (int i = 0; i < 24; i++) begin rand_view(); step(); end
    x_am = 0;

    // alarm at 08:00, approach it from 07:59
    steer(1, 8, 0);
    steer(0, 7, 59);
    run(320, 1, 1);

    // 12-hour conversion around 13:xx and 00:xx
    steer(0, 13, 0);
    run(40, 0, 1);
    steer(0, 0, 0);
    run(40, 0, 1);
    steer(0, 12, 34);
    run(60, 1, 1);

    // randomized traffic including occasional reset pulses
    for (int i = 0; i < 4000; i++) begin
      x_rst  = ($urandom_range(0, 299) == 0);
      x_en   = ($urandom_range(0, 9) < 8);
      x_da   = ($urandom_range(0, 4) == 0);
      x_ah   = ($urandom_range(0, 9) == 0);
      x_am   = ($urandom_range(0, 6) == 0);
      rand_view();
      step();
    end

    x_rst = 0; x_ah = 0; x_am = 0;
    step();
    repeat (3) @(negedge CP50);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
